// File: rtl/dut_preload_sequencer.sv
// Preload sequencer for the HLS "main" accelerator: streams bytes into slave RAM
// channel 0, pulses start_port, then times the run until done_port or a cycle limit.
//
// state  | meaning
// IDLE   | waiting for cmd_start
// FETCH  | byte_ready high, waiting for a stream byte
// WRITE  | channel 0 write held until Sout_DataRdy[0]
// START  | one-cycle start_port pulse, counter = 1
// RUN    | counting cycles until done_port or TIMEOUT
// REPORT | one-cycle result_valid pulse
module dut_preload_sequencer #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 200000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [ADDR_W:0]     cfg_nbytes,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [15:0]         S_Wdata_ram,
  output logic [7:0]          S_data_ram_size,
  input  logic [1:0]          Sout_DataRdy,
  output logic                start_port,
  input  logic                done_port,
  output logic                busy,
  output logic                result_valid,
  output logic [31:0]         result_cycles,
  output logic                result_timeout
);

  localparam logic [31:0] LIMIT = 32'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, START, RUN, REPORT} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     nbytes_q;
  logic [ADDR_W:0]     idx;
  logic [ADDR_W:0]     idx_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          data_q;
  logic                we_q;
  logic                unused;

  assign idx_next = idx + (ADDR_W+1)'(1);
  assign unused   = Sout_DataRdy[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      base_q         <= '0;
      nbytes_q       <= '0;
      idx            <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      we_q           <= 1'b0;
      byte_ready     <= 1'b0;
      start_port     <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_start) begin
            base_q         <= cfg_base_addr;
            nbytes_q       <= cfg_nbytes;
            idx            <= '0;
            result_cycles  <= '0;
            result_timeout <= 1'b0;
            busy           <= 1'b1;
            if (cfg_nbytes == '0) begin
              state      <= START;
              start_port <= 1'b1;
            end else begin
              state      <= FETCH;
              byte_ready <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (byte_valid) begin
            data_q     <= byte_data;
            addr_q     <= base_q + idx[ADDR_W-1:0];
            byte_ready <= 1'b0;
            we_q       <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (Sout_DataRdy[0]) begin
            we_q <= 1'b0;
            idx  <= idx_next;
            if (idx_next == nbytes_q) begin
              state      <= START;
              start_port <= 1'b1;
            end else begin
              state      <= FETCH;
              byte_ready <= 1'b1;
            end
          end
        end
        START: begin
          start_port    <= 1'b0;
          result_cycles <= 32'd1;
          if (done_port) begin
            state        <= REPORT;
            result_valid <= 1'b1;
          end else if (LIMIT <= 32'd1) begin
            result_cycles  <= LIMIT;
            result_timeout <= 1'b1;
            state          <= REPORT;
            result_valid   <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          // done wins over the limit when both land on the same cycle
          if (done_port) begin
            result_cycles <= result_cycles + 32'd1;
            state         <= REPORT;
            result_valid  <= 1'b1;
          end else if (result_cycles + 32'd1 >= LIMIT) begin
            result_cycles  <= LIMIT;
            result_timeout <= 1'b1;
            state          <= REPORT;
            result_valid   <= 1'b1;
          end else begin
            result_cycles <= result_cycles + 32'd1;
          end
        end
        REPORT: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign S_oe_ram        = 2'b00;
  assign S_we_ram        = {1'b0, we_q};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, (we_q ? addr_q : {ADDR_W{1'b0}})};
  assign S_Wdata_ram     = {8'h00, (we_q ? data_q : 8'h00)};
  assign S_data_ram_size = we_q ? 8'd8 : 8'd0;

endmodule

// File: tb/tb_dut_preload_sequencer.sv
// Self-checking bench for dut_preload_sequencer: randomized preload/run sequences
// compared against a transaction-level model of writes, start timing and result.
module tb_dut_preload_sequencer;

  localparam int TO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_start = 1'b0;
  logic [6:0]  cfg_base_addr = '0;
  logic [7:0]  cfg_nbytes = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic [1:0]  Sout_DataRdy = '0;
  logic        start_port;
  logic        done_port = 1'b0;
  logic        busy, result_valid, result_timeout;
  logic [31:0] result_cycles;

  int pass = 0;
  int total = 0;
  logic [7:0] bytes [0:127];

  dut_preload_sequencer #(.ADDR_W(7), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start),
    .cfg_base_addr(cfg_base_addr), .cfg_nbytes(cfg_nbytes),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_DataRdy(Sout_DataRdy), .start_port(start_port), .done_port(done_port),
    .busy(busy), .result_valid(result_valid), .result_cycles(result_cycles),
    .result_timeout(result_timeout)
  );

  always #5 clock = ~clock;

  // One full sequence. done_dly = cycles after the start cycle at which done_port
  // is high (negative = never). inject issues ignored commands and done noise.
  task automatic run_seq(input logic [6:0] base, input int n, input int gap_max,
                         input int wait_max, input bit rnd, input bit fixed_bytes,
                         input int done_dly, input bit inject);
    int sent, writes, gapc, ackc, cyc, start_cyc, last_ack, starts, rvs;
    int exp_cnt, unstable, overlap, stray;
    bit hs, in_write, finished, exp_to;
    logic [6:0] h_addr, exp_addr;
    logic [7:0] h_data;
    logic [31:0] held;
    for (int i = 0; i < n; i++) bytes[i] = fixed_bytes ? 8'(8'hA1 + i) : 8'($urandom);
    if (done_dly < 0 || done_dly + 1 > TO) begin exp_cnt = TO; exp_to = 1'b1; end
    else begin exp_cnt = done_dly + 1; exp_to = 1'b0; end
    sent = 0; writes = 0; gapc = 0; start_cyc = -1; last_ack = -1; starts = 0; rvs = 0;
    unstable = 0; overlap = 0; stray = 0; hs = 0; in_write = 0; finished = 0;
    h_addr = '0; h_data = '0;
    ackc = rnd ? int'($urandom_range(0, wait_max)) : wait_max;
    cfg_base_addr = base; cfg_nbytes = 8'(n); cmd_start = 1'b1;
    @(posedge clock); #1;
    cmd_start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_rise: got %0b expected 1", busy); else pass++;
    cyc = 0;
    while (cyc < 3000 && !(finished && !busy)) begin
      if (cyc > 0) begin @(posedge clock); #1; end
      done_port = 1'b0; Sout_DataRdy = 2'b00; cmd_start = 1'b0;
      if (hs) begin
        sent++;
        gapc = rnd ? int'($urandom_range(0, gap_max)) : gap_max;
      end
      if (sent < n && gapc == 0) begin byte_valid = 1'b1; byte_data = bytes[sent]; end
      else begin byte_valid = 1'b0; if (gapc > 0) gapc--; end
      hs = byte_valid && byte_ready;
      if (byte_ready && S_we_ram[0]) overlap++;
      if (S_oe_ram !== 2'b00 || S_we_ram[1] !== 1'b0 || S_addr_ram[13:7] !== 7'd0 ||
          S_Wdata_ram[15:8] !== 8'd0 || S_data_ram_size[7:4] !== 4'd0) stray++;
      if (S_we_ram[0]) begin
        if (in_write && (S_addr_ram[6:0] !== h_addr || S_Wdata_ram[7:0] !== h_data)) unstable++;
        h_addr = S_addr_ram[6:0]; h_data = S_Wdata_ram[7:0]; in_write = 1'b1;
        if (ackc > 0) ackc--;
        else begin
          Sout_DataRdy = 2'b01;
          if (writes < n) begin
            exp_addr = 7'(int'(base) + writes);
            total++;
            if (S_addr_ram[6:0] !== exp_addr)
              $display("FAIL wr_addr[%0d]: got %h expected %h", writes, S_addr_ram[6:0], exp_addr);
            else pass++;
            total++;
            if (S_Wdata_ram[7:0] !== bytes[writes])
              $display("FAIL wr_data[%0d]: got %h expected %h", writes, S_Wdata_ram[7:0], bytes[writes]);
            else pass++;
            total++;
            if (S_data_ram_size[3:0] !== 4'd8)
              $display("FAIL wr_size[%0d]: got %0d expected 8", writes, S_data_ram_size[3:0]);
            else pass++;
          end
          writes++; last_ack = cyc; in_write = 1'b0;
          ackc = rnd ? int'($urandom_range(0, wait_max)) : wait_max;
        end
      end else in_write = 1'b0;
      if (start_port) begin
        starts++;
        if (starts == 1) begin
          start_cyc = cyc;
          total++;
          if ((n == 0 && cyc != 0) || (n > 0 && cyc != last_ack + 1))
            $display("FAIL start_timing: got cycle %0d expected %0d", cyc, (n == 0) ? 0 : last_ack + 1);
          else pass++;
          total++;
          if (writes != n) $display("FAIL writes_before_start: got %0d expected %0d", writes, n);
          else pass++;
        end
      end
      if (start_cyc >= 0 && done_dly >= 0 && cyc - start_cyc == done_dly) done_port = 1'b1;
      if (inject && start_cyc < 0) done_port = 1'($urandom_range(0, 1));
      if (inject && busy && (cyc == 1 || (start_cyc >= 0 && cyc == start_cyc + 2))) begin
        cmd_start = 1'b1; cfg_nbytes = 8'(n ^ 5); cfg_base_addr = ~base;
      end
      if (result_valid) begin
        rvs++;
        if (rvs == 1) begin
          total++;
          if (result_cycles !== 32'(exp_cnt))
            $display("FAIL result_cycles: got %0d expected %0d", result_cycles, exp_cnt);
          else pass++;
          total++;
          if (result_timeout !== exp_to)
            $display("FAIL result_timeout: got %0b expected %0b", result_timeout, exp_to);
          else pass++;
          total++;
          if (start_cyc < 0 || cyc != start_cyc + exp_cnt)
            $display("FAIL result_timing: got cycle %0d expected %0d", cyc, start_cyc + exp_cnt);
          else pass++;
        end
        finished = 1'b1;
      end
      cyc++;
    end
    byte_valid = 1'b0; done_port = 1'b0; Sout_DataRdy = 2'b00; cmd_start = 1'b0;
    total++;
    if (!(finished && !busy)) $display("FAIL seq_complete: got finished=%0b busy=%0b expected 1/0", finished, busy);
    else pass++;
    total++;
    if (writes != n) $display("FAIL write_count: got %0d expected %0d", writes, n); else pass++;
    total++;
    if (starts != 1) $display("FAIL start_pulses: got %0d expected 1", starts); else pass++;
    total++;
    if (rvs != 1) $display("FAIL result_pulses: got %0d expected 1", rvs); else pass++;
    total++;
    if (unstable != 0) $display("FAIL write_hold: got %0d changes expected 0", unstable); else pass++;
    total++;
    if (overlap != 0) $display("FAIL ready_we_overlap: got %0d expected 0", overlap); else pass++;
    total++;
    if (stray != 0) $display("FAIL stray_bits: got %0d expected 0", stray); else pass++;
    held = result_cycles;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (result_cycles !== 32'(exp_cnt) || result_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL result_hold: got %0d/%0b expected %0d/0 (was %0d)", result_cycles, result_valid, exp_cnt, held);
    else pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #17;
    total++;
    if ({byte_ready, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
         start_port, busy, result_valid, result_cycles, result_timeout} !== '0)
      $display("FAIL reset_outputs: got nonzero expected all 0");
    else pass++;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) $display("FAIL idle_after_reset: got busy=%0b expected 0", busy);
    else pass++;
  endtask

  task automatic test_preload_run();   run_seq(7'h10, 4, 0, 0, 0, 1, 7, 0);  endtask
  task automatic test_wait_states();   run_seq(7'h10, 4, 2, 3, 0, 0, 5, 0);  endtask
  task automatic test_zero_len();      run_seq(7'h33, 0, 0, 0, 0, 0, 3, 0);  endtask
  task automatic test_wrap();          run_seq(7'h7E, 3, 0, 1, 0, 0, 2, 0);  endtask
  task automatic test_timeout();       run_seq(7'h05, 2, 0, 0, 0, 0, -1, 0); endtask
  task automatic test_done_in_start(); run_seq(7'h40, 2, 0, 0, 0, 0, 0, 0);  endtask
  task automatic test_limit_edge();
    run_seq(7'h01, 1, 0, 0, 0, 0, TO - 1, 0);
    run_seq(7'h02, 1, 0, 0, 0, 0, TO, 0);
  endtask
  task automatic test_ignored_cmd();   run_seq(7'h60, 5, 1, 1, 1, 0, 6, 1);  endtask

  task automatic test_reset_mid_write();
    int k;
    int bad;
    cfg_base_addr = 7'h20; cfg_nbytes = 8'd4; cmd_start = 1'b1;
    @(posedge clock); #1;
    cmd_start = 1'b0; byte_valid = 1'b1; byte_data = 8'h5A; Sout_DataRdy = 2'b00;
    k = 0;
    while (k < 20 && S_we_ram[0] !== 1'b1) begin @(posedge clock); #1; k++; end
    total++;
    if (S_we_ram[0] !== 1'b1) $display("FAIL reach_write: got we=%0b expected 1", S_we_ram[0]); else pass++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({byte_ready, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port, busy,
         result_valid, result_cycles, result_timeout} !== '0)
      $display("FAIL async_reset: got we=%0b busy=%0b expected all 0", S_we_ram, busy);
    else pass++;
    byte_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    bad = 0;
    repeat (5) begin @(posedge clock); #1; if (result_valid !== 1'b0 || busy !== 1'b0) bad++; end
    total++;
    if (bad != 0) $display("FAIL no_result_after_reset: got %0d bad cycles expected 0", bad); else pass++;
    run_seq(7'h20, 4, 0, 0, 0, 0, 4, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++)
      run_seq(7'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1, 0, int'($urandom_range(0, 23)) - 1,
              1'($urandom_range(0, 1)));
    run_seq(7'($urandom), 128, 0, 1, 1, 0, 9, 0);
  endtask

  initial begin
    test_reset();
    test_preload_run();
    test_wait_states();
    test_zero_len();
    test_wrap();
    test_timeout();
    test_done_in_start();
    test_limit_edge();
    test_ignored_cmd();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/dut_preload_sequencer.md
# dut_preload_sequencer

Test-harness sequencer that sits directly upstream of the HLS-generated `main` accelerator. It takes a byte stream, writes each byte into the accelerator's internal memories through channel 0 of the accelerator's slave RAM port, and pulses `start_port`. It then counts clock cycles until `done_port` and reports the count, or a timeout, as a single-cycle result.

## Interface
- `ADDR_W`, 7: width of one slave-port address channel; the `S_addr_ram` bus is `2*ADDR_W` bits.
- `TIMEOUT`, 200000000: run-phase cycle limit, compared against the cycle count defined under Operation.
- `clock` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_start` in 1: single-cycle request to begin a preload-and-run sequence; ignored unless `busy` is 0.
- `cfg_base_addr` in ADDR_W: first byte address; sampled on an accepted `cmd_start`.
- `cfg_nbytes` in ADDR_W+1: number of bytes to preload, 0..2^ADDR_W; sampled on an accepted `cmd_start`.
- `byte_valid` in 1, `byte_data` in 8: preload byte stream.
- `byte_ready` out 1: a byte transfers on any rising edge where `byte_valid` and `byte_ready` are both 1.
- `S_oe_ram` out 2: slave read enables; held at 0.
- `S_we_ram` out 2: slave write enables; bit 0 only, bit 1 held at 0.
- `S_addr_ram` out 2*ADDR_W: channel 0 address in bits [ADDR_W-1:0]; upper channel held at 0.
- `S_Wdata_ram` out 16: channel 0 data in bits [7:0]; bits [15:8] held at 0.
- `S_data_ram_size` out 8: channel 0 access size in bits [3:0], value 8 during writes; all other bits 0.
- `Sout_DataRdy` in 2: slave access acknowledge; only bit 0 is used.
- `start_port` out 1: accelerator start pulse.
- `done_port` in 1: accelerator completion.
- `busy` out 1: 1 in every state except IDLE.
- `result_valid` out 1: single-cycle pulse marking the result.
- `result_cycles` out 32: cycle count; held stable until the next accepted `cmd_start`.
- `result_timeout` out 1: 1 when the run was aborted by the cycle limit.

## Operation
- States and transitions:
  - IDLE: an accepted `cmd_start` latches the config and clears the byte index, `result_cycles` and `result_timeout`. Next state is FETCH, or START if `cfg_nbytes`=0.
  - FETCH: `byte_ready`=1. On a transfer, latch `byte_data` and go to WRITE.
  - WRITE: drive `S_we_ram[0]`=1, channel 0 address = (base + index) mod 2^ADDR_W, data = latched byte, size = 8. Hold these until `Sout_DataRdy[0]`=1 is sampled. On that edge, increment the index and go to START if it was the last byte, else to FETCH.
  - START: `start_port`=1 for exactly one cycle. The counter is set to 1. If `done_port`=1 in this cycle, go to REPORT with a count of 1; else go to RUN.
  - RUN: the counter increments on every edge. When `done_port`=1 is sampled, the count includes that cycle. If the count reaches TIMEOUT first, set `result_timeout`=1 and force the count to TIMEOUT. Either event moves to REPORT.
  - REPORT: `result_valid`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W, so writes wrap past the top address silently.
- `done_port` is ignored outside START and RUN.
- `cmd_start` asserted while `busy`=1 is dropped and has no effect.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Reset asserted mid-sequence aborts immediately and asynchronously: `S_we_ram` and `start_port` drop without waiting for a clock. No result is issued.
- Each byte takes at least 2 cycles (FETCH then WRITE); a 0-wait-state slave gives 2 cycles per byte.
- `busy` rises on the edge after `cmd_start` is accepted.
- `start_port` is high in the cycle after the last acknowledge, or in the cycle after `cmd_start` when `cfg_nbytes`=0.
- `result_valid` is high in the cycle after done or timeout is detected.
- `byte_ready` and `S_we_ram[0]` are never both 1.

## Test plan
- Preload and run: base=0x10, nbytes=4, bytes 0xA1..0xA4, `Sout_DataRdy[0]` acknowledging each write in the same cycle. Expect writes to addresses 0x10..0x13 with matching data and size 8, then one `start_port` pulse. With `done_port` high 7 cycles after start, expect `result_cycles`=8, `result_timeout`=0, and one `result_valid` pulse.
- Slave wait states and stalls: acknowledge each write after 3 cycles and gap `byte_valid` by 2 cycles. Expect write signals held stable until acknowledged, no dropped or duplicated byte, and exactly 4 writes.
- Zero-length and wrap: nbytes=0 gives `start_port` on the cycle after `cmd_start`. Base=0x7E with nbytes=3 gives writes to addresses 0x7E, 0x7F, 0x00.
- Timeout: TIMEOUT=20 with `done_port` never asserted. Expect `result_cycles`=20, `result_timeout`=1, a single `result_valid` pulse, and a return to IDLE.
- Done in the start cycle: `done_port` high in the same cycle as `start_port`. Expect `result_cycles`=1.
- Reset mid-write and ignored command: assert `reset` low during WRITE and expect all outputs 0 asynchronously, no `result_valid`, and correct operation of the next sequence. Separately, a `cmd_start` issued while `busy` is 1 must not change `cfg_nbytes` or the running count.
